perf_event_collector: RTL

//  Upstream stage of the performance counter block: collects raw per-cycle event sources
//  (level events plus per-commit-port events) and selects one event code per counter from
//  its mhpmevent selector. Emits a per-counter increment amount each cycle; an increment
//  may exceed 1 when several commit ports hit in the same cycle.

---
 rtl/perf_event_collector_pkg.sv | 40 ++++
 rtl/perf_sat_acc.sv | 56 +++++
 rtl/perf_event_collector.sv | 70 +++++++
 3 files changed

// File: rtl/perf_event_collector_pkg.sv
// Shared definitions for the performance event collector: event code encoding
// (same encoding as mhpmevent) and a helper that qualifies a selector value.
package perf_event_collector_pkg;

    localparam int unsigned NumPerfEvents = 25;

    typedef enum logic [4:0] {
        EvtNone          = 5'd0,
        EvtL1ICacheMiss  = 5'd1,
        EvtL1DCacheMiss  = 5'd2,
        EvtItlbMiss      = 5'd3,
        EvtDtlbMiss      = 5'd4,
        EvtLoad          = 5'd5,
        EvtStore         = 5'd6,
        EvtException     = 5'd7,
        EvtExceptionRet  = 5'd8,
        EvtBranch        = 5'd9,
        EvtBranchMispred = 5'd10,
        EvtCall          = 5'd11,
        EvtReturn        = 5'd12,
        EvtMsbFull       = 5'd13,
        EvtIfEmpty       = 5'd14,
        EvtL1ICacheAcc   = 5'd15,
        EvtL1DCacheAcc   = 5'd16,
        EvtL1DEvict      = 5'd17,
        EvtItlbFlush     = 5'd18,
        EvtIntAlu        = 5'd19,
        EvtFpu           = 5'd20,
        EvtCsr           = 5'd21,
        EvtStallIssue    = 5'd22,
        EvtStallCommit   = 5'd23,
        EvtReserved24    = 5'd24
    } perf_evt_e;

    // Code 0 means "no event"; codes at or above num_events are unimplemented.
    function automatic logic evt_code_valid(logic [4:0] code, int unsigned num_events);
        return (code != 5'd0) && (32'(code) < num_events);
    endfunction

endpackage

// File: rtl/perf_sat_acc.sv
// One counter's increment path: registers the raw per-cycle count, merges it
// with counts buffered while the consumer is held, and saturates the result.
module perf_sat_acc #(
    parameter int unsigned RawWidth = 2,
    parameter int unsigned AccWidth = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [RawWidth-1:0] raw_d_i,
    input  logic                hold_i,
    input  logic                ovf_clr_i,
    output logic [AccWidth-1:0] inc_o,
    output logic                ovf_o
);

    localparam int unsigned SumWidth = AccWidth + 1;

    logic [RawWidth-1:0] raw_q;
    logic [AccWidth-1:0] acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic [SumWidth-1:0] sum_full;
    logic [AccWidth-1:0] sum_sat;
    logic                sat;

    // Saturating merge of buffered and fresh counts; hold diverts it into the accumulator.
    always_comb begin
        sum_full = {1'b0, acc_q} + SumWidth'(raw_q);
        sat      = sum_full[AccWidth];
        sum_sat  = sat ? '1 : sum_full[AccWidth-1:0];
        inc_o    = '0;
        acc_d    = '0;
        if (hold_i) begin
            acc_d = sum_sat;
        end else begin
            inc_o = sum_sat;
        end
        // A saturation in the same cycle as a clear keeps the flag set.
        ovf_d = sat | (ovf_q & ~ovf_clr_i);
    end

    // Raw count, accumulator and sticky saturation flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            raw_q <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            raw_q <= raw_d_i;
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign ovf_o = ovf_q;

endmodule

// File: rtl/perf_event_collector.sv
// Collects level and per-commit-port events, selects one event per counter and
// emits a per-counter increment, buffering increments while downstream is held.
module perf_event_collector
    import perf_event_collector_pkg::*;
#(
    parameter int unsigned NumCounters    = 6,
    parameter int unsigned NumCommitPorts = 2,
    parameter int unsigned NumEvents      = NumPerfEvents,
    parameter int unsigned AccWidth       = 8
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [31:0]                              evt_i,
    input  logic [NumCommitPorts-1:0][31:0]          commit_evt_i,
    input  logic [NumCounters-1:0][4:0]              sel_i,
    input  logic [NumCounters-1:0]                   edge_mode_i,
    input  logic                                     inhibit_i,
    input  logic                                     hold_i,
    input  logic [NumCounters-1:0]                   ovf_clr_i,
    output logic [NumCounters-1:0][AccWidth-1:0]     inc_o,
    output logic [NumCounters-1:0]                   inc_valid_o,
    output logic [NumCounters-1:0]                   ovf_o
);

    // Enough for one level event plus one hit per commit port.
    localparam int unsigned RawWidth = $clog2(NumCommitPorts + 2);

    logic [31:0]                         prev_q;
    logic [NumCounters-1:0][RawWidth-1:0] raw_d;

    // Previous-cycle copy of the level events for edge detection; never gated.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q <= '0;
        end else begin
            prev_q <= evt_i;
        end
    end

    // Per-counter selection: level or rising edge, plus commit-port popcount.
    always_comb begin
        raw_d = '0;
        for (int unsigned i = 0; i < NumCounters; i++) begin
            if (!inhibit_i && evt_code_valid(sel_i[i], NumEvents)) begin
                raw_d[i] = RawWidth'(edge_mode_i[i] ? (evt_i[sel_i[i]] & ~prev_q[sel_i[i]])
                                                    : evt_i[sel_i[i]]);
                for (int unsigned p = 0; p < NumCommitPorts; p++) begin
                    raw_d[i] = raw_d[i] + RawWidth'(commit_evt_i[p][sel_i[i]]);
                end
            end
        end
    end

    for (genvar i = 0; i < NumCounters; i++) begin : g_ctr
        perf_sat_acc #(
            .RawWidth (RawWidth),
            .AccWidth (AccWidth)
        ) u_acc (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .raw_d_i   (raw_d[i]),
            .hold_i    (hold_i),
            .ovf_clr_i (ovf_clr_i[i]),
            .inc_o     (inc_o[i]),
            .ovf_o     (ovf_o[i])
        );
        assign inc_valid_o[i] = |inc_o[i];
    end

endmodule
